shared_ram: RTL and testbench
=============================

SHARED_RAM -- requirements
Module: shared_ram

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of requesting masters (1..8).
REQ-002 Parameter ADDR_W, default 32, byte-address width per port.
REQ-003 Parameter DATA_W, default 32, data width; multiple of 8; SEL_W = DATA_W/8.
REQ-004 Parameter DEPTH_LOG2, default 10, log2 of RAM depth in DATA_W words.
REQ-005 Parameter WAIT_CYCLES, default 1, extra wait states per access (0..15).
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 req_ce  input  NUM_PORTS  per-port request valid.
REQ-009 req_we  input  NUM_PORTS  per-port write enable (1 = write, 0 = read).
REQ-010 req_addr  input  NUM_PORTS*ADDR_W  per-port byte address, port i in slice [i*ADDR_W +: ADDR_W].
REQ-011 req_sel  input  NUM_PORTS*SEL_W  per-port byte-lane select, bit k = byte lane k.
REQ-012 req_wdata  input  NUM_PORTS*DATA_W  per-port write data.
REQ-013 rsp_rdata  output  NUM_PORTS*DATA_W  per-port registered read data.
REQ-014 rsp_ack  output  NUM_PORTS  per-port one-cycle completion pulse.
REQ-015 busy  output  1  high while state is not IDLE.

Function
REQ-016 Word index SHALL be req_addr[log2(SEL_W) +: DEPTH_LOG2]; upper address bits ignored (aliasing).
REQ-017 FSM states SHALL be IDLE, WAIT, COMMIT.
REQ-018 IDLE: if any eligible req_ce, grant one port at the edge, latch its we/addr/sel/wdata, load wait counter with WAIT_CYCLES, go WAIT if WAIT_CYCLES>0 else COMMIT.
REQ-019 WAIT: decrement counter each edge; go COMMIT at the edge where counter reaches 0.
REQ-020 COMMIT: at the edge leaving COMMIT perform the access, assert rsp_ack of granted port for exactly the following cycle, return to IDLE.
REQ-021 Latency: request sampled at grant edge E0 SHALL have ack high in cycle after edge E0+1+WAIT_CYCLES.
REQ-022 Write SHALL update only byte lanes with req_sel=1; sel=0 write SHALL leave RAM unchanged and still ack.
REQ-023 Read SHALL return full word regardless of sel on rsp_rdata of granted port, valid with ack and held until that port's next read ack.
REQ-024 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NUM_PORTS; last_grant updated on each grant.
REQ-025 Port whose rsp_ack is high in the current cycle SHALL be ineligible for grant at that cycle's edge.
REQ-026 Masters SHALL hold ce/we/addr/sel/wdata stable until ack; block latches at grant, so later changes do not affect the access in flight.
REQ-027 req_ce changes on non-granted ports during WAIT/COMMIT SHALL be ignored until IDLE.
REQ-028 Non-granted ports' rsp_ack SHALL stay 0 and rsp_rdata unchanged.
REQ-029 Back-to-back: IDLE cycle following ack SHALL grant the next eligible request (one idle cycle between accesses).

Reset
REQ-030 rst low SHALL immediately force state IDLE, counter 0, rsp_ack all 0, rsp_rdata all 0, busy 0, last_grant NUM_PORTS-1 (port 0 highest priority first).
REQ-031 Reset during WAIT/COMMIT SHALL abort the access; RAM write not performed unless commit edge already occurred.
REQ-032 RAM contents SHALL not be reset.

Verification
REQ-033 Defaults; port0 write addr 0x10, sel 4'b1111, data 0xDEADBEEF, then read 0x10 -> ack in cycle after edge E0+2 each time; rsp_rdata[31:0]=0xDEADBEEF.
REQ-034 Byte write: addr 0x10 sel 4'b0010 data 0x0000AA00 over 0xDEADBEEF -> read returns 0xDEADAABE? no: 0xDEADAAEF.
REQ-035 Both ports request continuously from reset -> grants alternate 0,1,0,1; each ack pulse exactly one cycle, one idle cycle between.
REQ-036 WAIT_CYCLES=0 and =3 builds: read latency measured = 1 and 4 edges from grant to commit respectively.
REQ-037 rst low two cycles into a WAIT_CYCLES=3 write of 0x12345678 to 0x20 -> no ack; later read of 0x20 returns prior contents.
REQ-038 DEPTH_LOG2=10: write 0x11111111 to 0x1000, read 0x0000 -> 0x11111111 (aliasing).

Source files
------------

// File: rtl/shared_ram.sv
// Single-port word RAM shared by NUM_PORTS masters through a round-robin arbiter,
// with WAIT_CYCLES wait states per access and per-port registered read data/ack.
module shared_ram #(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_ce,
  input  logic [NUM_PORTS-1:0]            req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] req_sel,
  input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata,
  output logic [NUM_PORTS*DATA_W-1:0]     rsp_rdata,
  output logic [NUM_PORTS-1:0]            rsp_ack,
  output logic                            busy
);
  localparam int SEL_W = DATA_W / 8;
  localparam int OFF   = (SEL_W > 1) ? $clog2(SEL_W) : 0;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [PW-1:0]         last_grant;
  logic [PW-1:0]         g_port;
  logic                  g_we;
  logic [DEPTH_LOG2-1:0] g_addr;
  logic [SEL_W-1:0]      g_sel;
  logic [DATA_W-1:0]     g_wdata;
  logic [DATA_W-1:0]     rdata_q [NUM_PORTS];
  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  grant_valid;
  logic [PW-1:0]         grant_idx;
  logic                  unused_addr;

  assign unused_addr = ^req_addr;
  assign busy        = (state != IDLE);

  // Round-robin search from last_grant+1; a port still showing its ack is skipped.
  always_comb begin
    int p;
    p           = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      p = (int'(last_grant) + k) % NUM_PORTS;
      if (!grant_valid && req_ce[p] && !rsp_ack[p]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(p);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= PW'(NUM_PORTS - 1);
      rsp_ack    <= '0;
      g_port     <= '0;
      g_we       <= 1'b0;
      g_addr     <= '0;
      g_sel      <= '0;
      g_wdata    <= '0;
      for (int i = 0; i < NUM_PORTS; i++) rdata_q[i] <= '0;
    end else begin
      rsp_ack <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            last_grant <= grant_idx;
            g_port     <= grant_idx;
            g_we       <= req_we[grant_idx];
            g_addr     <= req_addr[int'(grant_idx)*ADDR_W + OFF +: DEPTH_LOG2];
            g_sel      <= req_sel[int'(grant_idx)*SEL_W +: SEL_W];
            g_wdata    <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
            cnt        <= 4'(WAIT_CYCLES);
            state      <= (WAIT_CYCLES > 0) ? WAIT : COMMIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= COMMIT;
        end
        COMMIT: begin
          rsp_ack[g_port] <= 1'b1;
          if (!g_we) rdata_q[g_port] <= mem[g_addr];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM array is deliberately not reset; reset only guarantees no commit happens.
  always_ff @(posedge clk) begin
    if (state == COMMIT && g_we) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (g_sel[b]) mem[g_addr][b*8 +: 8] <= g_wdata[b*8 +: 8];
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rdata
    assign rsp_rdata[i*DATA_W +: DATA_W] = rdata_q[i];
  end

endmodule

// File: tb/tb_shared_ram.sv
// Directed bench for shared_ram: three builds (WAIT_CYCLES 1, 0, 3) driven from a
// vector table plus hand-written round-robin and reset-abort sequences.
module tb_shared_ram;

  typedef struct {
    int          d;
    int          p;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [1:0]  ce    [3];
  logic [1:0]  we    [3];
  logic [63:0] addr  [3];
  logic [7:0]  sel   [3];
  logic [63:0] wdata [3];
  logic [63:0] rdata [3];
  logic [1:0]  ack   [3];
  logic        busy  [3];

  vec_t        vecs [13];
  logic [31:0] last_rd [2];
  int          tests_run;
  int          errors;

  shared_ram dut_w1 (
    .clk(clk), .rst(rst), .req_ce(ce[0]), .req_we(we[0]), .req_addr(addr[0]),
    .req_sel(sel[0]), .req_wdata(wdata[0]), .rsp_rdata(rdata[0]), .rsp_ack(ack[0]),
    .busy(busy[0])
  );

  shared_ram #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .req_ce(ce[1]), .req_we(we[1]), .req_addr(addr[1]),
    .req_sel(sel[1]), .req_wdata(wdata[1]), .rsp_rdata(rdata[1]), .rsp_ack(ack[1]),
    .busy(busy[1])
  );

  shared_ram #(.WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst), .req_ce(ce[2]), .req_we(we[2]), .req_addr(addr[2]),
    .req_sel(sel[2]), .req_wdata(wdata[2]), .rsp_rdata(rdata[2]), .rsp_ack(ack[2]),
    .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One access on build d, port p; lat counts edges from grant to commit.
  task automatic apply_stimulus(input int d, input int p, input logic w, input logic [31:0] a,
                                input logic [3:0] s, input logic [31:0] wd,
                                output logic [31:0] rd, output int lat);
    int edges;
    @(negedge clk);
    ce[d][p] = 1'b1;
    we[d][p] = w;
    addr[d][p*32 +: 32] = a;
    sel[d][p*4 +: 4] = s;
    wdata[d][p*32 +: 32] = wd;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!ack[d][p] && edges < 20);
    rd  = rdata[d][p*32 +: 32];
    lat = edges - 1;
    @(negedge clk);
    ce[d][p] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          n;
    logic [1:0]  exp_ack;

    tests_run = 0;
    errors    = 0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int i = 0; i < 3; i++) begin
      ce[i] = '0; we[i] = '0; addr[i] = '0; sel[i] = '0; wdata[i] = '0;
    end
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_busy", 64'(busy[0]), 64'd0);
    check_output("reset_ack", 64'(ack[0]), 64'd0);
    check_output("reset_rdata", rdata[0], 64'd0);
    @(negedge clk);
    rst = 1'b1;

    vecs[0]  = '{0, 0, 1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{0, 0, 1'b0, 32'h10,   4'hF, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{0, 0, 1'b1, 32'h10,   4'h2, 32'h0000AA00, 32'h0};
    vecs[3]  = '{0, 0, 1'b0, 32'h10,   4'h0, 32'h0,        32'hDEADAAEF};
    vecs[4]  = '{0, 0, 1'b1, 32'h10,   4'h0, 32'h12345678, 32'h0};
    vecs[5]  = '{0, 0, 1'b0, 32'h10,   4'hF, 32'h0,        32'hDEADAAEF};
    vecs[6]  = '{0, 0, 1'b1, 32'h1000, 4'hF, 32'h11111111, 32'h0};
    vecs[7]  = '{0, 0, 1'b0, 32'h0,    4'hF, 32'h0,        32'h11111111};
    vecs[8]  = '{0, 1, 1'b1, 32'h20,   4'hF, 32'hCAFEF00D, 32'h0};
    vecs[9]  = '{0, 1, 1'b0, 32'h20,   4'hF, 32'h0,        32'hCAFEF00D};
    vecs[10] = '{0, 1, 1'b1, 32'h24,   4'hF, 32'h01020304, 32'h0};
    vecs[11] = '{0, 1, 1'b1, 32'h24,   4'h9, 32'hAABBCCDD, 32'h0};
    vecs[12] = '{0, 1, 1'b0, 32'h24,   4'hF, 32'h0,        32'hAA0203DD};

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].d, vecs[i].p, vecs[i].we, vecs[i].addr, vecs[i].sel,
                     vecs[i].wdata, rd, lat);
      check_output($sformatf("vec%0d_latency", i), 64'(lat), 64'(wc_of(vecs[i].d) + 1));
      if (!vecs[i].we) begin
        check_output($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
        last_rd[vecs[i].p] = vecs[i].exp_rdata;
        check_output($sformatf("vec%0d_other_rdata", i),
                     64'(rdata[0][(1 - vecs[i].p)*32 +: 32]), 64'(last_rd[1 - vecs[i].p]));
      end
    end

    // Zero- and three-wait-state builds.
    apply_stimulus(1, 0, 1'b1, 32'h20, 4'hF, 32'hA5A5A5A5, rd, lat);
    check_output("w0_write_latency", 64'(lat), 64'd1);
    apply_stimulus(1, 0, 1'b0, 32'h20, 4'hF, 32'h0, rd, lat);
    check_output("w0_read_latency", 64'(lat), 64'd1);
    check_output("w0_read_rdata", 64'(rd), 64'hA5A5A5A5);
    apply_stimulus(2, 0, 1'b1, 32'h20, 4'hF, 32'hA5A5A5A5, rd, lat);
    check_output("w3_write_latency", 64'(lat), 64'd4);
    apply_stimulus(2, 0, 1'b0, 32'h20, 4'hF, 32'h0, rd, lat);
    check_output("w3_read_latency", 64'(lat), 64'd4);
    check_output("w3_read_rdata", 64'(rd), 64'hA5A5A5A5);

    // Reset clears outputs but not RAM; both ports then request continuously.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("rr_reset_rdata", rdata[0], 64'd0);
    check_output("rr_reset_ack", 64'(ack[0]), 64'd0);
    check_output("rr_reset_busy", 64'(busy[0]), 64'd0);
    ce[0] = 2'b11;
    we[0] = 2'b00;
    addr[0] = {32'h20, 32'h10};
    sel[0] = 8'hFF;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ack[0] == 2'b00 && n < 20);
    check_output("rr_first_ack", 64'(ack[0]), 64'b01);
    check_output("rr_first_wait", 64'(n), 64'd3);
    check_output("rr_idle_in_ack", 64'(busy[0]), 64'd0);
    for (int k = 1; k < 12; k++) begin
      @(posedge clk);
      #1;
      exp_ack = (k % 3 == 0) ? ((((k / 3) % 2) == 1) ? 2'b10 : 2'b01) : 2'b00;
      check_output($sformatf("rr_ack_cycle%0d", k), 64'(ack[0]), 64'(exp_ack));
    end
    check_output("rr_rdata_p0", 64'(rdata[0][31:0]), 64'hDEADAAEF);
    check_output("rr_rdata_p1", 64'(rdata[0][63:32]), 64'hCAFEF00D);
    @(negedge clk);
    ce[0] = 2'b00;
    n = 0;
    while (busy[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("rr_drain", 64'(busy[0]), 64'd0);
    repeat (2) @(negedge clk);

    // Reset two cycles into a three-wait-state write must abort it.
    ce[2][0] = 1'b1;
    we[2][0] = 1'b1;
    addr[2][31:0] = 32'h20;
    sel[2][3:0] = 4'hF;
    wdata[2][31:0] = 32'h12345678;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_output("abort_busy_before", 64'(busy[2]), 64'd1);
    rst = 1'b0;
    #1;
    check_output("abort_busy_after", 64'(busy[2]), 64'd0);
    ce[2][0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("abort_no_ack%0d", k), 64'(ack[2]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(2, 0, 1'b0, 32'h20, 4'hF, 32'h0, rd, lat);
    check_output("abort_read_latency", 64'(lat), 64'd4);
    check_output("abort_read_rdata", 64'(rd), 64'hA5A5A5A5);

    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

endmodule
